focal_scan_controller: RTL and testbench

FOCAL_SCAN_CONTROLLER -- requirements
Module: focal_scan_controller

---
 rtl/focal_scan_if.sv | 46 ++++
 rtl/focal_scan_controller.sv | 128 ++++++++++++
 tb/tb_focal_scan_controller.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/focal_scan_if.sv
// Calculator-side and output-stream signals of the focal scan controller.
// The master modport is the controller's view; the slave modport is the calculator/consumer view.
interface focal_scan_if #(
  parameter int DW_INPUT = 8,
  parameter int ANGLE_DW = 8,
  parameter int DW_TERM  = 27,
  parameter int N_ELEM   = 32,
  parameter int DW_K     = 8
) ();
  localparam int EW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

  logic                       calc_rst;
  logic                       calc_configure;
  logic                       calc_ack;
  logic [DW_INPUT-1:0]        calc_r_0;
  logic [ANGLE_DW-1:0]        calc_angle;
  logic signed [DW_TERM-1:0]  calc_term_pos;
  logic signed [DW_TERM-1:0]  calc_term_neg;
  logic                       calc_last;
  logic                       calc_ready;

  logic                       out_valid;
  logic                       out_ready;
  logic signed [DW_TERM-1:0]  out_term_pos;
  logic signed [DW_TERM-1:0]  out_term_neg;
  logic [DW_K-1:0]            out_point_idx;
  logic [EW-1:0]              out_elem_idx;
  logic                       out_last_elem;
  logic                       out_last_point;

  modport master (
    output calc_rst, calc_configure, calc_ack, calc_r_0, calc_angle,
    input  calc_term_pos, calc_term_neg, calc_last, calc_ready,
    output out_valid, out_term_pos, out_term_neg, out_point_idx, out_elem_idx,
    output out_last_elem, out_last_point,
    input  out_ready
  );

  modport slave (
    input  calc_rst, calc_configure, calc_ack, calc_r_0, calc_angle,
    output calc_term_pos, calc_term_neg, calc_last, calc_ready,
    input  out_valid, out_term_pos, out_term_neg, out_point_idx, out_elem_idx,
    input  out_last_elem, out_last_point,
    output out_ready
  );
endinterface

// File: rtl/focal_scan_controller.sv
// Sequences a delay-term calculator over num_points focal points of N_ELEM elements each,
// forwarding every term pair through a valid/ready output stream.
module focal_scan_controller #(
  parameter int DW_INPUT = 8,
  parameter int ANGLE_DW = 8,
  parameter int DW_TERM  = 27,
  parameter int N_ELEM   = 32,
  parameter int DW_K     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [DW_INPUT-1:0] r_0,
  input  logic [ANGLE_DW-1:0] angle,
  input  logic [DW_K-1:0]     num_points,
  focal_scan_if.master        bus,
  output logic                busy,
  output logic                done,
  output logic                seq_err
);
  localparam int EW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CFG       = 3'd1;
  localparam logic [2:0] WAIT_TERM = 3'd2;
  localparam logic [2:0] PRESENT   = 3'd3;
  localparam logic [2:0] ACK       = 3'd4;
  localparam logic [2:0] FLUSH     = 3'd5;
  localparam logic [2:0] DONE      = 3'd6;

  logic [2:0]                state;
  logic                      aborting;
  logic [DW_INPUT-1:0]       r0_q;
  logic [ANGLE_DW-1:0]       angle_q;
  logic [DW_K-1:0]           np_q;
  logic [DW_K-1:0]           point_idx;
  logic [EW-1:0]             elem_idx;
  logic signed [DW_TERM-1:0] term_pos_q;
  logic signed [DW_TERM-1:0] term_neg_q;
  logic                      last_elem;
  logic                      last_point;
  logic                      abortable;

  assign last_elem  = (elem_idx == EW'(N_ELEM - 1));
  assign last_point = (point_idx == np_q - DW_K'(1));
  assign abortable  = (state == CFG) || (state == WAIT_TERM) ||
                      (state == PRESENT) || (state == ACK);

  // Abort is checked ahead of the state case so it beats a simultaneous output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      aborting   <= 1'b0;
      r0_q       <= '0;
      angle_q    <= '0;
      np_q       <= '0;
      point_idx  <= '0;
      elem_idx   <= '0;
      term_pos_q <= '0;
      term_neg_q <= '0;
      seq_err    <= 1'b0;
    end else if (abort && abortable) begin
      state    <= FLUSH;
      aborting <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            seq_err <= 1'b0;
            if (num_points != '0) begin
              r0_q      <= r_0;
              angle_q   <= angle;
              np_q      <= num_points;
              point_idx <= '0;
              elem_idx  <= '0;
              state     <= CFG;
            end else begin
              state <= DONE;
            end
          end
        end
        CFG: state <= WAIT_TERM;
        WAIT_TERM: begin
          if (bus.calc_ready) begin
            term_pos_q <= bus.calc_term_pos;
            term_neg_q <= bus.calc_term_neg;
            if (bus.calc_last != last_elem) seq_err <= 1'b1;
            state <= PRESENT;
          end
        end
        PRESENT: begin
          if (bus.out_ready) state <= (last_elem && last_point) ? FLUSH : ACK;
        end
        ACK: begin
          if (last_elem) begin
            elem_idx  <= '0;
            point_idx <= point_idx + DW_K'(1);
          end else begin
            elem_idx <= elem_idx + EW'(1);
          end
          state <= WAIT_TERM;
        end
        FLUSH: begin
          aborting <= 1'b0;
          state    <= aborting ? IDLE : DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.calc_rst       = rst || (state == FLUSH);
  assign bus.calc_configure = (state == CFG);
  assign bus.calc_ack       = (state == ACK);
  assign bus.calc_r_0       = r0_q;
  assign bus.calc_angle     = angle_q;
  assign bus.out_valid      = (state == PRESENT);
  assign bus.out_term_pos   = term_pos_q;
  assign bus.out_term_neg   = term_neg_q;
  assign bus.out_point_idx  = point_idx;
  assign bus.out_elem_idx   = elem_idx;
  assign bus.out_last_elem  = (state == PRESENT) && last_elem;
  assign bus.out_last_point = (state == PRESENT) && last_point;
  assign busy               = (state != IDLE);
  assign done               = (state == DONE);
endmodule

// File: tb/tb_focal_scan_controller.sv
// Bench for focal_scan_controller: a calculator model, a stream scoreboard,
// table-driven scans and hand-written abort / seq_err / mid-scan reset sequences.
module tb_focal_scan_controller;
  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [7:0] r_0, angle, num_points;
  logic       busy, done, seq_err;

  focal_scan_if bus ();

  focal_scan_controller dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .r_0(r_0), .angle(angle),
    .num_points(num_points), .bus(bus), .busy(busy), .done(done), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  pt;
    logic [4:0]  el;
    logic [26:0] pos;
    logic [26:0] neg;
    logic        le;
    logic        lp;
    logic [7:0]  r0;
    logic [7:0]  ang;
  } out_t;

  typedef struct packed {
    out_t o;
    logic hs;
  } obs_t;

  typedef struct {
    int np; int r0; int ang; bit rnd; int acks; int cfgs;
  } vec_t;

  out_t exp_q[$];
  obs_t obs_q[$];
  int   checks = 0, errors = 0;
  int   cfg_cnt = 0, ack_cnt = 0, crst_cnt = 0, done_cnt = 0, hs_cnt = 0;
  int   n = 0, last_at = 31, base_val = 1000, ready_limit = 1 << 30;
  bit   rand_mode = 1'b0;

  // Calculator model: term number n counts acks since the last configure.
  assign bus.calc_term_pos = 27'(base_val + 7 * n);
  assign bus.calc_term_neg = 27'(-(base_val + 7 * n));
  assign bus.calc_last     = ((n % 32) == last_at);

  function automatic obs_t sampleOut();
    obs_t s;
    s.o.pt  = bus.out_point_idx;
    s.o.el  = bus.out_elem_idx;
    s.o.pos = bus.out_term_pos;
    s.o.neg = bus.out_term_neg;
    s.o.le  = bus.out_last_elem;
    s.o.lp  = bus.out_last_point;
    s.o.r0  = bus.calc_r_0;
    s.o.ang = bus.calc_angle;
    s.hs    = bus.out_ready;
    return s;
  endfunction

  function automatic out_t mkExp(int p, int e, int np, int r0, int ang);
    out_t r;
    int   v;
    v     = 1000 + r0 + 7 * (p * 32 + e);
    r.pt  = 8'(p);
    r.el  = 5'(e);
    r.pos = 27'(v);
    r.neg = 27'(-v);
    r.le  = (e == 31);
    r.lp  = (p == np - 1);
    r.r0  = 8'(r0);
    r.ang = 8'(ang);
    return r;
  endfunction

  always @(negedge clk) begin
    if (bus.calc_configure) begin
      cfg_cnt <= cfg_cnt + 1;
      n       <= 0;
    end
    if (bus.calc_ack) begin
      ack_cnt <= ack_cnt + 1;
      n       <= n + 1;
    end
    if (bus.calc_rst && !rst) crst_cnt <= crst_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (bus.out_valid) begin
      obs_q.push_back(sampleOut());
      if (bus.out_ready) hs_cnt <= hs_cnt + 1;
    end
  end

  // Ready lines change just after the active edge; ready_limit lets a sequence park the stream.
  initial begin
    bus.calc_ready = 1'b1;
    bus.out_ready  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.calc_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready  = (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1) && (hs_cnt < ready_limit);
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drainCheck();
    obs_t s;
    while (obs_q.size() > 0) begin
      s = obs_q.pop_front();
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected output actual=%0h required=none", s.o);
      end else begin
        checkOutput("stream record", 128'(s.o), 128'(exp_q[0]));
        if (s.hs) void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic pulseStart(input int np, input int r0, input int ang);
    @(negedge clk);
    start      = 1'b1;
    r_0        = 8'(r0);
    angle      = 8'(ang);
    num_points = 8'(np);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input int np, input int r0, input int ang, input bit rnd,
                               input int exp_acks, input int exp_cfgs, input bit exp_seq);
    int c0, a0, k0, d0, h0, t;
    rand_mode = rnd;
    base_val  = 1000 + r0;
    for (int p = 0; p < np; p++)
      for (int e = 0; e < 32; e++) exp_q.push_back(mkExp(p, e, np, r0, ang));
    c0 = cfg_cnt; a0 = ack_cnt; k0 = crst_cnt; d0 = done_cnt; h0 = hs_cnt;
    pulseStart(np, r0, ang);
    if (np == 0) checkOutput("done one cycle after empty start", 128'(done), 128'(1));
    t = 0;
    while (done_cnt == d0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) begin
      checks++;
      errors++;
      $display("[TB] FAIL scan timeout actual=no done required=done");
    end
    @(negedge clk);
    drainCheck();
    checkOutput("configure count", 128'(cfg_cnt - c0), 128'(exp_cfgs));
    checkOutput("ack count", 128'(ack_cnt - a0), 128'(exp_acks));
    checkOutput("calc_rst pulses", 128'(crst_cnt - k0), 128'(exp_cfgs));
    checkOutput("done count", 128'(done_cnt - d0), 128'(1));
    checkOutput("handshake count", 128'(hs_cnt - h0), 128'(np * 32));
    checkOutput("terms left over", 128'(exp_q.size()), 128'(0));
    checkOutput("busy after scan", 128'(busy), 128'(0));
    checkOutput("seq_err after scan", 128'(seq_err), 128'(exp_seq));
    rand_mode = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    int d0, k0, h0, t;
    vecs[0] = '{np: 2, r0: 10,  ang: 45,  rnd: 1'b0, acks: 63, cfgs: 1};
    vecs[1] = '{np: 2, r0: 200, ang: 3,   rnd: 1'b1, acks: 63, cfgs: 1};
    vecs[2] = '{np: 0, r0: 77,  ang: 9,   rnd: 1'b0, acks: 0,  cfgs: 0};
    vecs[3] = '{np: 1, r0: 255, ang: 255, rnd: 1'b1, acks: 31, cfgs: 1};
    vecs[4] = '{np: 3, r0: 1,   ang: 128, rnd: 1'b0, acks: 95, cfgs: 1};

    rst = 1'b1; start = 1'b0; abort = 1'b0; r_0 = '0; angle = '0; num_points = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset calc_rst", 128'(bus.calc_rst), 128'(1));
    checkOutput("reset busy", 128'(busy), 128'(0));
    checkOutput("reset out_valid", 128'(bus.out_valid), 128'(0));
    checkOutput("reset done", 128'(done), 128'(0));
    checkOutput("reset configure/ack", 128'({bus.calc_configure, bus.calc_ack}), 128'(0));
    checkOutput("reset seq_err", 128'(seq_err), 128'(0));
    checkOutput("reset idx/config", 128'({bus.out_point_idx, bus.out_elem_idx, bus.calc_r_0}), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    checkOutput("calc_rst released", 128'(bus.calc_rst), 128'(0));

    for (int i = 0; i < 5; i++)
      applyStimulus(vecs[i].np, vecs[i].r0, vecs[i].ang, vecs[i].rnd,
                    vecs[i].acks, vecs[i].cfgs, 1'b0);

    // Calculator flags last one element early: error latches but the scan runs to completion.
    last_at = 30;
    applyStimulus(1, 20, 7, 1'b0, 31, 1, 1'b1);
    last_at = 31;
    repeat (3) @(negedge clk);
    checkOutput("seq_err held while idle", 128'(seq_err), 128'(1));
    applyStimulus(1, 5, 6, 1'b0, 31, 1, 1'b0);

    // Abort while element 5 of point 0 is stalled in PRESENT.
    base_val    = 1000 + 33;
    ready_limit = hs_cnt + 5;
    for (int e = 0; e < 6; e++) exp_q.push_back(mkExp(0, e, 2, 33, 44));
    d0 = done_cnt; k0 = crst_cnt; h0 = hs_cnt;
    pulseStart(2, 33, 44);
    t = 0;
    while (!(bus.out_valid && !bus.out_ready && bus.out_elem_idx == 5) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      checks++;
      errors++;
      $display("[TB] FAIL abort stall timeout actual=no stall required=stall at elem 5");
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort out_valid drop", 128'(bus.out_valid), 128'(0));
    checkOutput("abort calc_rst", 128'(bus.calc_rst), 128'(1));
    @(negedge clk);
    checkOutput("abort back to idle", 128'(busy), 128'(0));
    repeat (3) @(negedge clk);
    checkOutput("abort no done", 128'(done_cnt - d0), 128'(0));
    checkOutput("abort calc_rst pulses", 128'(crst_cnt - k0), 128'(1));
    checkOutput("abort handshakes", 128'(hs_cnt - h0), 128'(5));
    drainCheck();
    checkOutput("abort pending term", 128'(exp_q.size()), 128'(1));
    exp_q.delete();
    ready_limit = 1 << 30;

    // Reset in the middle of a scan, then a clean scan must start from (0,0).
    d0 = done_cnt;
    base_val = 1000 + 10;
    pulseStart(2, 10, 45);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid rst calc_rst", 128'(bus.calc_rst), 128'(1));
    checkOutput("mid rst busy/valid", 128'({busy, bus.out_valid}), 128'(0));
    checkOutput("mid rst idx/config", 128'({bus.out_point_idx, bus.out_elem_idx, bus.calc_r_0}), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid rst no done", 128'(done_cnt - d0), 128'(0));
    obs_q.delete();
    exp_q.delete();
    applyStimulus(2, 10, 45, 1'b1, 63, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
